// File: rtl/dma_rw_join_pkg.sv
// Shared AXI4 channel and bundle typedefs for the read/write port joiner.
package dma_rw_join_pkg;

    localparam int unsigned IdWidth   = 4;
    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned UserWidth = 1;

    typedef enum logic [1:0] {
        RespOkay   = 2'b00,
        RespExOkay = 2'b01,
        RespSlvErr = 2'b10,
        RespDecErr = 2'b11
    } axi_resp_e;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic [5:0]           atop;
        logic [UserWidth-1:0] user;
    } aw_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [StrbWidth-1:0] strb;
        logic                 last;
        logic [UserWidth-1:0] user;
    } w_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        axi_resp_e            resp;
        logic [UserWidth-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic [UserWidth-1:0] user;
    } ar_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
        axi_resp_e            resp;
        logic                 last;
        logic [UserWidth-1:0] user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } dma_axi_req_t;

    typedef struct packed {
        logic     aw_ready;
        logic     ar_ready;
        logic     w_ready;
        b_chan_t  b;
        logic     b_valid;
        r_chan_t  r;
        logic     r_valid;
    } dma_axi_resp_t;

endpackage

// File: rtl/dma_rw_join_if.sv
// AXI4 port bundle (request + response) with master and slave views.
interface dma_rw_join_if;
    import dma_rw_join_pkg::*;

    dma_axi_req_t  req;
    dma_axi_resp_t resp;

    modport master (output req, input resp);
    modport slave  (input req, output resp);

endinterface

// File: rtl/dma_rw_spill.sv
// Two-entry valid/ready spill register; Bypass turns it into plain wires.
module dma_rw_spill #(
    parameter type payload_t = logic,
    parameter bit  Bypass    = 1'b0
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     i_valid,
    output logic     o_ready,
    input  payload_t i_data,
    output logic     o_valid,
    input  logic     i_ready,
    output payload_t o_data
);

    logic     r_a_full, r_b_full;
    payload_t r_a_data, r_b_data;
    logic     w_spill_ready, w_a_fill, w_a_drain, w_b_fill, w_b_drain;

    // Slot a takes new beats; slot b only catches a beat the sink refused.
    assign w_spill_ready = !r_a_full || !r_b_full;
    assign w_a_fill      = i_valid && w_spill_ready;
    assign w_a_drain     = r_a_full && !r_b_full;
    assign w_b_fill      = w_a_drain && !i_ready;
    assign w_b_drain     = r_b_full && i_ready;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_a_full <= 1'b0;
            r_b_full <= 1'b0;
            r_a_data <= '0;
            r_b_data <= '0;
        end else begin
            if (w_a_fill) r_a_data <= i_data;
            if (w_b_fill) r_b_data <= r_a_data;
            r_a_full <= w_a_fill || (r_a_full && !w_a_drain);
            r_b_full <= w_b_fill || (r_b_full && !w_b_drain);
        end
    end

    assign o_ready = Bypass ? i_ready : w_spill_ready;
    assign o_valid = Bypass ? i_valid : (r_a_full || r_b_full);
    assign o_data  = Bypass ? i_data  : (r_b_full ? r_b_data : r_a_data);

endmodule

// File: rtl/dma_rw_join.sv
// Joins a read-only and a write-only AXI4 slave port onto one full AXI4 master port.
module dma_rw_join
    import dma_rw_join_pkg::*;
#(
    parameter type axi_req_t  = dma_axi_req_t,
    parameter type axi_resp_t = dma_axi_resp_t,
    parameter bit  CutReq     = 1'b0,
    parameter bit  CutRsp     = 1'b0
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  axi_req_t  slv_read_req_i,
    output axi_resp_t slv_read_resp_o,
    input  axi_req_t  slv_write_req_i,
    output axi_resp_t slv_write_resp_o,
    output axi_req_t  mst_req_o,
    input  axi_resp_t mst_resp_i,
    output logic      misuse_o
);

    aw_chan_t w_aw;
    w_chan_t  w_w;
    ar_chan_t w_ar;
    r_chan_t  w_r;
    b_chan_t  w_b;
    logic     w_aw_valid, w_w_valid, w_ar_valid, w_r_valid, w_b_valid;
    logic     w_aw_ready, w_w_ready, w_ar_ready, w_r_ready, w_b_ready;
    logic     r_misuse;
    logic     w_unused_ok;

    dma_rw_spill #(.payload_t(aw_chan_t), .Bypass(!CutReq)) u_spill_aw (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_valid (slv_write_req_i.aw_valid),
        .o_ready (w_aw_ready),
        .i_data  (slv_write_req_i.aw),
        .o_valid (w_aw_valid),
        .i_ready (mst_resp_i.aw_ready),
        .o_data  (w_aw)
    );

    dma_rw_spill #(.payload_t(w_chan_t), .Bypass(!CutReq)) u_spill_w (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_valid (slv_write_req_i.w_valid),
        .o_ready (w_w_ready),
        .i_data  (slv_write_req_i.w),
        .o_valid (w_w_valid),
        .i_ready (mst_resp_i.w_ready),
        .o_data  (w_w)
    );

    dma_rw_spill #(.payload_t(ar_chan_t), .Bypass(!CutReq)) u_spill_ar (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_valid (slv_read_req_i.ar_valid),
        .o_ready (w_ar_ready),
        .i_data  (slv_read_req_i.ar),
        .o_valid (w_ar_valid),
        .i_ready (mst_resp_i.ar_ready),
        .o_data  (w_ar)
    );

    dma_rw_spill #(.payload_t(r_chan_t), .Bypass(!CutRsp)) u_spill_r (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_valid (mst_resp_i.r_valid),
        .o_ready (w_r_ready),
        .i_data  (mst_resp_i.r),
        .o_valid (w_r_valid),
        .i_ready (slv_read_req_i.r_ready),
        .o_data  (w_r)
    );

    dma_rw_spill #(.payload_t(b_chan_t), .Bypass(!CutRsp)) u_spill_b (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_valid (mst_resp_i.b_valid),
        .o_ready (w_b_ready),
        .i_data  (mst_resp_i.b),
        .o_valid (w_b_valid),
        .i_ready (slv_write_req_i.b_ready),
        .o_data  (w_b)
    );

    // Channels a port must not use are simply never wired toward the master.
    always_comb begin
        mst_req_o          = '0;
        mst_req_o.aw       = w_aw;
        mst_req_o.aw_valid = w_aw_valid;
        mst_req_o.w        = w_w;
        mst_req_o.w_valid  = w_w_valid;
        mst_req_o.b_ready  = w_b_ready;
        mst_req_o.ar       = w_ar;
        mst_req_o.ar_valid = w_ar_valid;
        mst_req_o.r_ready  = w_r_ready;

        slv_read_resp_o          = '0;
        slv_read_resp_o.ar_ready = w_ar_ready;
        slv_read_resp_o.r        = w_r;
        slv_read_resp_o.r_valid  = w_r_valid;

        slv_write_resp_o          = '0;
        slv_write_resp_o.aw_ready = w_aw_ready;
        slv_write_resp_o.w_ready  = w_w_ready;
        slv_write_resp_o.b        = w_b;
        slv_write_resp_o.b_valid  = w_b_valid;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_misuse <= 1'b0;
        end else if (slv_read_req_i.aw_valid || slv_read_req_i.w_valid ||
                     slv_write_req_i.ar_valid) begin
            r_misuse <= 1'b1;
        end
    end

    assign misuse_o = r_misuse;

    assign w_unused_ok = ^{slv_read_req_i.aw, slv_read_req_i.w, slv_read_req_i.b_ready,
                           slv_write_req_i.ar, slv_write_req_i.r_ready};

endmodule

// File: tb/tb_dma_rw_join.sv
// Bench for dma_rw_join: directed checks on an uncut instance, scoreboarded random traffic
// plus latency/reset checks on a fully cut instance.
module tb_dma_rw_join;
    import dma_rw_join_pkg::*;

    localparam int AwW = $bits(aw_chan_t);
    localparam int WW  = $bits(w_chan_t);
    localparam int ArW = $bits(ar_chan_t);
    localparam int RW  = $bits(r_chan_t);
    localparam int BW  = $bits(b_chan_t);
    localparam int NCyc   = 2000;
    localparam int NDrain = 400;

    logic clk, rst_n, misuse0, misuse1;
    int   n_checks, n_fail, n_popped;
    logic mon_en;
    logic src_v [5];
    logic [63:0] src_d [5];
    logic snk_r [5];
    logic [63:0] sb_aw[$], sb_w[$], sb_ar[$], sb_r[$], sb_b[$];

    dma_rw_join_if u_rd0 ();
    dma_rw_join_if u_wr0 ();
    dma_rw_join_if u_mst0 ();
    dma_rw_join_if u_rd1 ();
    dma_rw_join_if u_wr1 ();
    dma_rw_join_if u_mst1 ();

    dma_rw_join #(.CutReq(1'b0), .CutRsp(1'b0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .slv_read_req_i(u_rd0.req), .slv_read_resp_o(u_rd0.resp),
        .slv_write_req_i(u_wr0.req), .slv_write_resp_o(u_wr0.resp),
        .mst_req_o(u_mst0.req), .mst_resp_i(u_mst0.resp), .misuse_o(misuse0)
    );

    dma_rw_join #(.CutReq(1'b1), .CutRsp(1'b1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .slv_read_req_i(u_rd1.req), .slv_read_resp_o(u_rd1.resp),
        .slv_write_req_i(u_wr1.req), .slv_write_resp_o(u_wr1.resp),
        .mst_req_o(u_mst1.req), .mst_resp_i(u_mst1.resp), .misuse_o(misuse1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] chan_mask(input int c);
        int w;
        case (c)
            0: w = AwW;
            1: w = WW;
            2: w = ArW;
            3: w = RW;
            default: w = BW;
        endcase
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic void sb_push(input int c, input logic [63:0] d);
        case (c)
            0: sb_aw.push_back(d);
            1: sb_w.push_back(d);
            2: sb_ar.push_back(d);
            3: sb_r.push_back(d);
            default: sb_b.push_back(d);
        endcase
    endfunction

    function automatic int sb_size(input int c);
        case (c)
            0: return sb_aw.size();
            1: return sb_w.size();
            2: return sb_ar.size();
            3: return sb_r.size();
            default: return sb_b.size();
        endcase
    endfunction

    function automatic logic [63:0] sb_pop(input int c);
        case (c)
            0: return sb_aw.pop_front();
            1: return sb_w.pop_front();
            2: return sb_ar.pop_front();
            3: return sb_r.pop_front();
            default: return sb_b.pop_front();
        endcase
    endfunction

    // Channels of the cut instance: 0 AW, 1 W, 2 AR (toward master), 3 R, 4 B (toward slaves).
    task automatic drive_src(input int c, input logic v, input logic [63:0] d);
        case (c)
            0: begin u_wr1.req.aw_valid = v;  u_wr1.req.aw = d[AwW-1:0]; end
            1: begin u_wr1.req.w_valid = v;   u_wr1.req.w = d[WW-1:0]; end
            2: begin u_rd1.req.ar_valid = v;  u_rd1.req.ar = d[ArW-1:0]; end
            3: begin u_mst1.resp.r_valid = v; u_mst1.resp.r = d[RW-1:0]; end
            default: begin u_mst1.resp.b_valid = v; u_mst1.resp.b = d[BW-1:0]; end
        endcase
    endtask

    task automatic drive_sink(input int c, input logic r);
        snk_r[c] = r;
        case (c)
            0: u_mst1.resp.aw_ready = r;
            1: u_mst1.resp.w_ready = r;
            2: u_mst1.resp.ar_ready = r;
            3: u_rd1.req.r_ready = r;
            default: u_wr1.req.b_ready = r;
        endcase
    endtask

    function automatic logic in_ready(input int c);
        case (c)
            0: return u_wr1.resp.aw_ready;
            1: return u_wr1.resp.w_ready;
            2: return u_rd1.resp.ar_ready;
            3: return u_mst1.req.r_ready;
            default: return u_mst1.req.b_ready;
        endcase
    endfunction

    function automatic logic out_valid(input int c);
        case (c)
            0: return u_mst1.req.aw_valid;
            1: return u_mst1.req.w_valid;
            2: return u_mst1.req.ar_valid;
            3: return u_rd1.resp.r_valid;
            default: return u_wr1.resp.b_valid;
        endcase
    endfunction

    function automatic logic [63:0] out_data(input int c);
        logic [63:0] d;
        d = '0;
        case (c)
            0: d[AwW-1:0] = u_mst1.req.aw;
            1: d[WW-1:0]  = u_mst1.req.w;
            2: d[ArW-1:0] = u_mst1.req.ar;
            3: d[RW-1:0]  = u_rd1.resp.r;
            default: d[BW-1:0] = u_wr1.resp.b;
        endcase
        return d;
    endfunction

    task automatic idle_all();
        u_rd0.req = '0;  u_wr0.req = '0;  u_mst0.resp = '0;
        u_rd1.req = '0;  u_wr1.req = '0;  u_mst1.resp = '0;
        for (int c = 0; c < 5; c++) begin
            src_v[c] = 1'b0;
            src_d[c] = '0;
            snk_r[c] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_all();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic misuse_case(input int k);
        do_reset();
        u_mst0.resp.aw_ready = 1'b1;
        u_mst0.resp.w_ready  = 1'b1;
        u_mst0.resp.ar_ready = 1'b1;
        case (k)
            0: u_rd0.req.aw_valid = 1'b1;
            1: u_rd0.req.w_valid  = 1'b1;
            default: u_wr0.req.ar_valid = 1'b1;
        endcase
        #1;
        check($sformatf("misuse%0d_leak", k),
              {u_mst0.req.aw_valid, u_mst0.req.w_valid, u_mst0.req.ar_valid}, 0);
        check($sformatf("misuse%0d_early", k), misuse0, 0);
        @(posedge clk); #1;
        u_rd0.req = '0;
        u_wr0.req = '0;
        check($sformatf("misuse%0d_set", k), misuse0, 1);
        repeat (3) @(posedge clk);
        #1 check($sformatf("misuse%0d_held", k), misuse0, 1);
    endtask

    // Scoreboard monitor: pops and compares whenever an output beat handshakes.
    initial begin : monitor
        logic        stall [5];
        logic [63:0] held [5];
        logic        v;
        logic [63:0] d;
        for (int c = 0; c < 5; c++) begin stall[c] = 1'b0; held[c] = '0; end
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                for (int c = 0; c < 5; c++) stall[c] = 1'b0;
            end else begin
                check("tieoffs", {u_rd1.resp.aw_ready, u_rd1.resp.w_ready, u_rd1.resp.b_valid,
                                  u_wr1.resp.ar_ready, u_wr1.resp.r_valid}, 0);
                for (int c = 0; c < 5; c++) begin
                    v = out_valid(c);
                    d = out_data(c);
                    if (stall[c]) begin
                        check($sformatf("hold_valid_ch%0d", c), v, 1);
                        check($sformatf("hold_data_ch%0d", c), d, held[c]);
                    end
                    if (v && snk_r[c]) begin
                        check($sformatf("beat_expected_ch%0d", c), sb_size(c) != 0, 1);
                        if (sb_size(c) != 0) begin
                            check($sformatf("beat_data_ch%0d", c), d, sb_pop(c));
                            n_popped++;
                        end
                    end
                    stall[c] = v && !snk_r[c];
                    held[c]  = d;
                end
            end
        end
    end

    initial begin
        n_checks = 0; n_fail = 0; n_popped = 0; mon_en = 1'b0;
        do_reset();

        check("rst_misuse", misuse0, 0);
        check("rst_cut_valids", {u_mst1.req.aw_valid, u_mst1.req.w_valid, u_mst1.req.ar_valid,
                                 u_rd1.resp.r_valid, u_wr1.resp.b_valid}, 0);
        check("rst_cut_ready", {u_wr1.resp.aw_ready, u_wr1.resp.w_ready, u_rd1.resp.ar_ready}, 3'b111);

        // Uncut AR passes through in the same cycle.
        u_rd0.req.ar.addr = 32'h1000;
        u_rd0.req.ar.id = 4'd3;
        u_rd0.req.ar_valid = 1'b1;
        u_mst0.resp.ar_ready = 1'b1;
        #1;
        check("ar_valid", u_mst0.req.ar_valid, 1);
        check("ar_addr", u_mst0.req.ar.addr, 32'h1000);
        check("ar_id", u_mst0.req.ar.id, 3);
        check("ar_ready", {u_rd0.resp.ar_ready, u_wr0.resp.ar_ready}, 2'b10);
        @(posedge clk); #1;
        u_rd0.req.ar_valid = 1'b0;

        // Write burst: AW, four W beats, B on the write port only.
        u_wr0.req.aw.addr = 32'h2000;
        u_wr0.req.aw.len = 8'd3;
        u_wr0.req.aw.id = 4'd1;
        u_wr0.req.aw_valid = 1'b1;
        u_mst0.resp.aw_ready = 1'b1;
        #1;
        check("aw_fwd", {u_mst0.req.aw_valid, u_mst0.req.aw.addr, u_mst0.req.aw.len}, {1'b1, 32'h2000, 8'd3});
        check("aw_ready", {u_wr0.resp.aw_ready, u_rd0.resp.aw_ready}, 2'b10);
        @(posedge clk); #1;
        u_wr0.req.aw_valid = 1'b0;
        u_mst0.resp.w_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            u_wr0.req.w.data = 32'hA0 + i;
            u_wr0.req.w.last = (i == 3);
            u_wr0.req.w_valid = 1'b1;
            #1;
            check($sformatf("w_beat%0d", i), {u_mst0.req.w_valid, u_mst0.req.w.last, u_mst0.req.w.data},
                  {1'b1, i == 3, 32'hA0 + i});
            check($sformatf("w_ready%0d", i), {u_wr0.resp.w_ready, u_rd0.resp.w_ready}, 2'b10);
            @(posedge clk); #1;
        end
        u_wr0.req.w_valid = 1'b0;
        u_mst0.resp.b.id = 4'd1;
        u_mst0.resp.b.resp = RespOkay;
        u_mst0.resp.b_valid = 1'b1;
        u_wr0.req.b_ready = 1'b1;
        #1;
        check("b_write_port", {u_wr0.resp.b_valid, u_wr0.resp.b.id, u_wr0.resp.b.resp}, {1'b1, 4'd1, 2'b00});
        check("b_read_port", u_rd0.resp.b_valid, 0);
        check("b_ready_fwd", u_mst0.req.b_ready, 1);
        u_wr0.req.b_ready = 1'b0;
        u_rd0.req.b_ready = 1'b1;
        #1 check("b_ready_src", u_mst0.req.b_ready, 0);
        u_mst0.resp.b_valid = 1'b0;
        u_mst0.resp.r.data = 32'h1234_5678;
        u_mst0.resp.r_valid = 1'b1;
        u_rd0.req.r_ready = 1'b1;
        #1;
        check("r_read_port", {u_rd0.resp.r_valid, u_rd0.resp.r.data}, {1'b1, 32'h1234_5678});
        check("r_write_port", u_wr0.resp.r_valid, 0);
        check("r_ready_fwd", u_mst0.req.r_ready, 1);
        u_rd0.req.r_ready = 1'b0;
        u_wr0.req.r_ready = 1'b1;
        #1 check("r_ready_src", u_mst0.req.r_ready, 0);
        check("no_misuse", misuse0, 0);

        for (int k = 0; k < 3; k++) misuse_case(k);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("misuse_cleared", misuse0, 0);

        // Random traffic through the cut instance.
        do_reset();
        mon_en = 1'b1;
        for (int cyc = 0; cyc < NCyc; cyc++) begin
            @(negedge clk);
            for (int c = 0; c < 5; c++) begin
                if (src_v[c] && in_ready(c)) begin
                    sb_push(c, src_d[c]);
                    src_v[c] = 1'b0;
                end
            end
            @(posedge clk); #1;
            for (int c = 0; c < 5; c++) begin
                if (!src_v[c] && cyc < NCyc - NDrain && $urandom_range(9) < 7) begin
                    src_v[c] = 1'b1;
                    src_d[c] = {$urandom, $urandom} & chan_mask(c);
                end
                drive_src(c, src_v[c], src_d[c]);
                drive_sink(c, cyc >= NCyc - NDrain || $urandom_range(9) < 6);
            end
        end
        @(negedge clk);
        mon_en = 1'b0;
        for (int c = 0; c < 5; c++) check($sformatf("sb_empty_ch%0d", c), sb_size(c), 0);
        check("traffic_seen", n_popped > 500, 1);
        check("cut_no_misuse", misuse1, 0);

        // R through the response cut: one cycle later, held stable under back-pressure.
        do_reset();
        u_mst1.resp.r.data = 32'hDEAD_BEEF;
        u_mst1.resp.r.last = 1'b1;
        u_mst1.resp.r_valid = 1'b1;
        #1 check("r_cut_lat0", {u_rd1.resp.r_valid, u_mst1.req.r_ready}, 2'b01);
        @(posedge clk); #1;
        u_mst1.resp.r_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("r_cut_stall%0d", i), {u_rd1.resp.r_valid, u_rd1.resp.r.last, u_rd1.resp.r.data},
                  {2'b11, 32'hDEAD_BEEF});
            if (i < 5) begin @(posedge clk); #1; end
        end
        u_rd1.req.r_ready = 1'b1;
        @(posedge clk); #1;
        check("r_cut_done", u_rd1.resp.r_valid, 0);

        // Eight back-to-back W beats through the request cut.
        do_reset();
        u_mst1.resp.w_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            u_wr1.req.w.data = 32'(k);
            u_wr1.req.w_valid = (k < 8);
            #1;
            if (k < 8) check($sformatf("w_cut_ready%0d", k), u_wr1.resp.w_ready, 1);
            if (k >= 1 && k <= 8)
                check($sformatf("w_cut_beat%0d", k - 1), {u_mst1.req.w_valid, u_mst1.req.w.data},
                      {1'b1, 32'(k - 1)});
            else
                check($sformatf("w_cut_idle%0d", k), u_mst1.req.w_valid, 0);
            @(posedge clk); #1;
        end

        // Reset in the middle of a stalled transfer discards the buffered beats.
        do_reset();
        u_wr1.req.aw.addr = 32'h3000;
        u_wr1.req.aw_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("aw_cut_full", {u_mst1.req.aw_valid, u_wr1.resp.aw_ready}, 2'b10);
        rst_n = 1'b0;
        u_wr1.req.aw_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("aw_cut_flushed", {u_mst1.req.aw_valid, u_wr1.resp.aw_ready}, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
